// File: rtl/clock_pkg.sv
// Shared types and constants for the clock controller and its prescaler.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAST = 2'd2
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned SEC_MIN_MAX   = 59;
    localparam int unsigned HRS24_MAX     = 23;
    localparam int unsigned HRS12_MAX     = 11;

    // Highest hour value the counter should show for the selected display mode.
    function automatic int unsigned hrs_max(input logic mode12);
        return mode12 ? HRS12_MAX : HRS24_MAX;
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Wrap counter 0..PRESCALE-1 that produces a one-cycle tick on its last count.
module clock_prescaler #(
    parameter int unsigned PRESCALE = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;

    // Clear takes precedence so every fresh run starts a full period.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (inc) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = inc && (presc_q == LAST);

endmodule

// File: rtl/clock_ctrl.sv
// Run/stop/fast-forward sequencer, hour-mode configuration and one-shot alarm
// sitting between the board controls and the sec/min/hrs counter block.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned PRESCALE = 100,
    parameter int unsigned WIDTH    = WIDTH_DEFAULT
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic             io_start,
    input  logic             io_stop,
    input  logic             io_fast,
    input  logic             io_mode12,
    input  logic             io_alarm_arm,
    input  logic             io_alarm_ack,
    input  logic [WIDTH-1:0] io_alarm_hrs,
    input  logic [WIDTH-1:0] io_alarm_min,
    input  logic [WIDTH-1:0] io_count_sec,
    input  logic [WIDTH-1:0] io_count_min,
    input  logic [WIDTH-1:0] io_count_hrs,
    output logic             io_en,
    output logic [WIDTH-1:0] io_count_max,
    output logic [WIDTH-1:0] io_count_max_hrs,
    output logic             io_running,
    output logic             io_alarm
);

    localparam logic [WIDTH-1:0] SEC_MIN_LIMIT = WIDTH'(SEC_MIN_MAX);
    localparam logic [WIDTH-1:0] HRS_RESET     = WIDTH'(HRS24_MAX);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_max_hrs_q;
    logic [WIDTH-1:0] count_max_hrs_d;
    logic [WIDTH-1:0] alm_hrs_q;
    logic [WIDTH-1:0] alm_hrs_d;
    logic [WIDTH-1:0] alm_min_q;
    logic [WIDTH-1:0] alm_min_d;
    logic             armed_q;
    logic             armed_d;
    logic             alarm_q;
    logic             alarm_d;

    logic             in_run;
    logic             presc_tick;
    logic             alarm_match;

    assign in_run = (state_q == RUN);

    clock_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (io_clock),
        .rst  (io_reset),
        .inc  (in_run),
        .clr  (!in_run),
        .tick (presc_tick)
    );

    // Stop outranks every other request, whatever the current state.
    always_comb begin
        state_d = state_q;
        if (io_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (io_start) state_d = io_fast ? FAST : RUN;
                RUN:     if (io_fast)  state_d = FAST;
                FAST:    if (!io_fast) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Hour mode is only followed while stopped so the counter never sees its
    // limit move underneath a running count.
    always_comb begin
        count_max_hrs_d = count_max_hrs_q;
        if (state_q == IDLE) begin
            count_max_hrs_d = WIDTH'(hrs_max(io_mode12));
        end
    end

    assign alarm_match = armed_q
                      && (io_count_hrs == alm_hrs_q)
                      && (io_count_min == alm_min_q)
                      && (io_count_sec == '0);

    // Arming beats a coincident match; a match beats a coincident ack.
    always_comb begin
        alm_hrs_d = alm_hrs_q;
        alm_min_d = alm_min_q;
        armed_d   = armed_q;
        alarm_d   = alarm_q;
        if (io_alarm_arm) begin
            alm_hrs_d = io_alarm_hrs;
            alm_min_d = io_alarm_min;
            armed_d   = 1'b1;
        end else if (alarm_match) begin
            armed_d   = 1'b0;
        end
        if (alarm_match && !io_alarm_arm) begin
            alarm_d = 1'b1;
        end else if (io_alarm_ack) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state_q         <= IDLE;
            count_max_hrs_q <= HRS_RESET;
            alm_hrs_q       <= '0;
            alm_min_q       <= '0;
            armed_q         <= 1'b0;
            alarm_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_max_hrs_q <= count_max_hrs_d;
            alm_hrs_q       <= alm_hrs_d;
            alm_min_q       <= alm_min_d;
            armed_q         <= armed_d;
            alarm_q         <= alarm_d;
        end
    end

    assign io_en            = presc_tick || (state_q == FAST);
    assign io_running       = (state_q != IDLE);
    assign io_alarm         = alarm_q;
    assign io_count_max     = SEC_MIN_LIMIT;
    assign io_count_max_hrs = count_max_hrs_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with a behavioural sec/min/hrs counter attached.
module tb_clock_ctrl;

    localparam int P      = 10;
    localparam int W      = 32;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_FAST = 2;

    logic clk = 1'b0;
    logic io_reset, io_start, io_stop, io_fast, io_mode12, io_alarm_arm, io_alarm_ack;
    logic [W-1:0] io_alarm_hrs, io_alarm_min;
    logic io_en, io_running, io_alarm;
    logic [W-1:0] io_count_max, io_count_max_hrs;

    logic [W-1:0] cnt_sec = '0;
    logic [W-1:0] cnt_min = '0;
    logic [W-1:0] cnt_hrs = '0;
    logic         load_req = 1'b0;
    logic [W-1:0] load_sec = '0;
    logic [W-1:0] load_min = '0;
    logic [W-1:0] load_hrs = '0;

    int n_cmp = 0;
    int n_err = 0;

    int           m_state = S_IDLE;
    int           m_age   = 0;
    int           m_next  = S_IDLE;
    bit           m_armed = 1'b0;
    bit           m_alarm = 1'b0;
    bit           m_match = 1'b0;
    logic [W-1:0] m_ah    = '0;
    logic [W-1:0] m_am    = '0;
    logic [W-1:0] m_maxh  = 23;

    always #5 clk = ~clk;

    clock_ctrl #(.PRESCALE(P), .WIDTH(W)) dut (
        .io_clock         (clk),
        .io_reset         (io_reset),
        .io_start         (io_start),
        .io_stop          (io_stop),
        .io_fast          (io_fast),
        .io_mode12        (io_mode12),
        .io_alarm_arm     (io_alarm_arm),
        .io_alarm_ack     (io_alarm_ack),
        .io_alarm_hrs     (io_alarm_hrs),
        .io_alarm_min     (io_alarm_min),
        .io_count_sec     (cnt_sec),
        .io_count_min     (cnt_min),
        .io_count_hrs     (cnt_hrs),
        .io_en            (io_en),
        .io_count_max     (io_count_max),
        .io_count_max_hrs (io_count_max_hrs),
        .io_running       (io_running),
        .io_alarm         (io_alarm)
    );

    // Stand-in for the counter block, wired to the controller's outputs.
    always @(posedge clk) begin
        if (load_req) begin
            cnt_sec <= load_sec;
            cnt_min <= load_min;
            cnt_hrs <= load_hrs;
        end else if (io_en) begin
            if (cnt_sec >= io_count_max) begin
                cnt_sec <= '0;
                if (cnt_min >= io_count_max) begin
                    cnt_min <= '0;
                    cnt_hrs <= (cnt_hrs >= io_count_max_hrs) ? '0 : cnt_hrs + 1;
                end else begin
                    cnt_min <= cnt_min + 1;
                end
            end else begin
                cnt_sec <= cnt_sec + 1;
            end
        end
    end

    // Reference model: m_age counts cycles since RUN was entered, a tick is due
    // on every PRESCALE-th cycle of that run.
    always @(posedge clk) begin
        if (io_reset) begin
            m_state = S_IDLE;
            m_age   = 0;
            m_armed = 1'b0;
            m_alarm = 1'b0;
            m_ah    = '0;
            m_am    = '0;
            m_maxh  = 23;
        end else begin
            m_match = m_armed && cnt_hrs == m_ah && cnt_min == m_am && cnt_sec == 0;
            if (m_state == S_IDLE) m_maxh = io_mode12 ? 11 : 23;
            if (io_alarm_arm) begin
                m_ah    = io_alarm_hrs;
                m_am    = io_alarm_min;
                m_armed = 1'b1;
            end else if (m_match) begin
                m_armed = 1'b0;
            end
            if (m_match && !io_alarm_arm) m_alarm = 1'b1;
            else if (io_alarm_ack)        m_alarm = 1'b0;
            if (io_stop)                  m_next = S_IDLE;
            else if (m_state == S_IDLE)   m_next = io_start ? (io_fast ? S_FAST : S_RUN) : S_IDLE;
            else                          m_next = io_fast ? S_FAST : S_RUN;
            m_age   = (m_next == S_RUN && m_state == S_RUN) ? m_age + 1 : 0;
            m_state = m_next;
        end
    end

    function automatic bit exp_en();
        return (m_state == S_RUN && (m_age % P) == P - 1) || m_state == S_FAST;
    endfunction

    task automatic load_counter(input int h, input int m, input int s);
        load_hrs = h; load_min = m; load_sec = s; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic go_idle();
        io_stop = 1'b1;
        @(negedge clk);
        io_stop = 1'b0;
    endtask

    task automatic test_reset();
        io_reset = 1'b1;
        load_counter(0, 0, 0);
        @(negedge clk);
        n_cmp++; if (io_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_en: got %0b want 0", io_en); end
        n_cmp++; if (io_running !== 1'b0) begin n_err++; $display("[TB] FAIL reset_running: got %0b want 0", io_running); end
        n_cmp++; if (io_alarm !== 1'b0) begin n_err++; $display("[TB] FAIL reset_alarm: got %0b want 0", io_alarm); end
        n_cmp++; if (io_count_max !== 59) begin n_err++; $display("[TB] FAIL reset_max: got %0d want 59", io_count_max); end
        n_cmp++; if (io_count_max_hrs !== 23) begin n_err++; $display("[TB] FAIL reset_max_hrs: got %0d want 23", io_count_max_hrs); end
        io_reset = 1'b0;
    endtask

    task automatic test_start_run();
        load_counter(0, 0, 0);
        io_start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            io_start = 1'b0;
            n_cmp++; if (io_en !== ((k % P) == 0)) begin n_err++; $display("[TB] FAIL run_tick k=%0d: got %0b want %0b", k, io_en, (k % P) == 0); end
            n_cmp++; if (io_running !== 1'b1) begin n_err++; $display("[TB] FAIL run_running k=%0d: got %0b want 1", k, io_running); end
            if (k == P + 1) begin
                n_cmp++; if (cnt_sec !== 1) begin n_err++; $display("[TB] FAIL run_first_sec: got %0d want 1", cnt_sec); end
            end
        end
    endtask

    task automatic test_stop_priority();
        go_idle();
        io_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            io_start = 1'b0;
        end
        io_start = 1'b1; io_stop = 1'b1;
        @(negedge clk);
        io_start = 1'b0; io_stop = 1'b0;
        n_cmp++; if (io_running !== 1'b0) begin n_err++; $display("[TB] FAIL stop_prio_running: got %0b want 0", io_running); end
        n_cmp++; if (io_en !== 1'b0) begin n_err++; $display("[TB] FAIL stop_prio_en: got %0b want 0", io_en); end
        @(negedge clk);
        n_cmp++; if (io_en !== 1'b0) begin n_err++; $display("[TB] FAIL idle_en: got %0b want 0", io_en); end
        io_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            io_start = 1'b0;
            n_cmp++; if (io_en !== (k == P)) begin n_err++; $display("[TB] FAIL resume_tick k=%0d: got %0b want %0b", k, io_en, k == P); end
        end
    endtask

    task automatic test_fast();
        go_idle();
        io_start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            io_start = 1'b0;
        end
        io_fast = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            n_cmp++; if (io_en !== 1'b1) begin n_err++; $display("[TB] FAIL fast_en j=%0d: got %0b want 1", j, io_en); end
            if (j == 5) io_fast = 1'b0;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++; if (io_en !== (k == P)) begin n_err++; $display("[TB] FAIL fast_return k=%0d: got %0b want %0b", k, io_en, k == P); end
            n_cmp++; if (io_running !== 1'b1) begin n_err++; $display("[TB] FAIL fast_running k=%0d: got %0b want 1", k, io_running); end
        end
    endtask

    task automatic test_mode();
        go_idle();
        io_mode12 = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (io_count_max_hrs !== 11) begin n_err++; $display("[TB] FAIL mode12_idle: got %0d want 11", io_count_max_hrs); end
        io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0; io_mode12 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_cmp++; if (io_count_max_hrs !== 11) begin n_err++; $display("[TB] FAIL mode_frozen k=%0d: got %0d want 11", k, io_count_max_hrs); end
        end
        go_idle();
        n_cmp++; if (io_count_max_hrs !== m_maxh) begin n_err++; $display("[TB] FAIL mode_stop_edge: got %0d want %0d", io_count_max_hrs, m_maxh); end
        @(negedge clk);
        n_cmp++; if (io_count_max_hrs !== 23) begin n_err++; $display("[TB] FAIL mode_after_stop: got %0d want 23", io_count_max_hrs); end
    endtask

    task automatic test_alarm();
        bit found;
        go_idle();
        load_counter(0, 0, 0);
        io_fast = 1'b1; io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        io_alarm_arm = 1'b1; io_alarm_hrs = 0; io_alarm_min = 2;
        @(negedge clk);
        io_alarm_arm = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            n_cmp++; if (io_alarm !== m_alarm) begin n_err++; $display("[TB] FAIL alarm_wait i=%0d: got %0b want %0b", i, io_alarm, m_alarm); end
            if (io_alarm === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("[TB] FAIL alarm_timeout: got 0 want 1 within 200 cycles"); end
        n_cmp++; if (cnt_min !== 2 || cnt_sec !== 1) begin n_err++; $display("[TB] FAIL alarm_timing: got %0d:%0d want 2:1", cnt_min, cnt_sec); end
        io_alarm_ack = 1'b1;
        @(negedge clk);
        io_alarm_ack = 1'b0;
        n_cmp++; if (io_alarm !== 1'b0) begin n_err++; $display("[TB] FAIL alarm_ack: got %0b want 0", io_alarm); end
        load_counter(23, 58, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_cmp++; if (io_alarm !== 1'b0) begin n_err++; $display("[TB] FAIL alarm_oneshot i=%0d: got %0b want 0", i, io_alarm); end
        end
        n_cmp++; if (cnt_hrs !== 0 || cnt_min !== 3 || cnt_sec !== 0) begin
            n_err++; $display("[TB] FAIL alarm_wrap_time: got %0d:%0d:%0d want 0:3:0", cnt_hrs, cnt_min, cnt_sec);
        end
        io_fast = 1'b0;
    endtask

    task automatic test_alarm_ack_race();
        go_idle();
        load_counter(5, 10, 0);
        io_alarm_arm = 1'b1; io_alarm_hrs = 5; io_alarm_min = 10;
        @(negedge clk);
        io_alarm_arm = 1'b0;
        @(negedge clk);
        n_cmp++; if (io_alarm !== 1'b1) begin n_err++; $display("[TB] FAIL idle_match: got %0b want 1", io_alarm); end
        io_alarm_arm = 1'b1;
        @(negedge clk);
        io_alarm_arm = 1'b0; io_alarm_ack = 1'b1;
        @(negedge clk);
        io_alarm_ack = 1'b0;
        n_cmp++; if (io_alarm !== 1'b1) begin n_err++; $display("[TB] FAIL ack_vs_match: got %0b want 1", io_alarm); end
        io_alarm_ack = 1'b1;
        @(negedge clk);
        io_alarm_ack = 1'b0;
        n_cmp++; if (io_alarm !== 1'b0) begin n_err++; $display("[TB] FAIL ack_plain: got %0b want 0", io_alarm); end
    endtask

    task automatic test_reset_mid();
        go_idle();
        io_mode12 = 1'b1;
        load_counter(7, 0, 0);
        io_alarm_arm = 1'b1; io_alarm_hrs = 7; io_alarm_min = 0;
        @(negedge clk);
        io_alarm_arm = 1'b0;
        @(negedge clk);
        io_fast = 1'b1; io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        n_cmp++; if (io_en !== 1'b1 || io_alarm !== 1'b1 || io_count_max_hrs !== 11) begin
            n_err++; $display("[TB] FAIL pre_reset: got en=%0b alarm=%0b maxh=%0d want 1 1 11", io_en, io_alarm, io_count_max_hrs);
        end
        io_reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (io_en !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_en: got %0b want 0", io_en); end
        n_cmp++; if (io_running !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_running: got %0b want 0", io_running); end
        n_cmp++; if (io_alarm !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_alarm: got %0b want 0", io_alarm); end
        n_cmp++; if (io_count_max_hrs !== 23) begin n_err++; $display("[TB] FAIL mid_reset_max_hrs: got %0d want 23", io_count_max_hrs); end
        io_reset = 1'b0; io_fast = 1'b0; io_mode12 = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_cmp++; if (io_en !== exp_en()) begin n_err++; $display("[TB] FAIL rnd_en i=%0d: got %0b want %0b", i, io_en, exp_en()); end
            n_cmp++; if (io_running !== (m_state != S_IDLE)) begin n_err++; $display("[TB] FAIL rnd_running i=%0d: got %0b want %0b", i, io_running, m_state != S_IDLE); end
            n_cmp++; if (io_alarm !== m_alarm) begin n_err++; $display("[TB] FAIL rnd_alarm i=%0d: got %0b want %0b", i, io_alarm, m_alarm); end
            n_cmp++; if (io_count_max_hrs !== m_maxh) begin n_err++; $display("[TB] FAIL rnd_max_hrs i=%0d: got %0d want %0d", i, io_count_max_hrs, m_maxh); end
            n_cmp++; if (io_count_max !== 59) begin n_err++; $display("[TB] FAIL rnd_max i=%0d: got %0d want 59", i, io_count_max); end
            io_reset     = ($urandom_range(0, 599) == 0);
            io_start     = ($urandom_range(0, 7) == 0);
            io_stop      = ($urandom_range(0, 39) == 0);
            io_alarm_ack = ($urandom_range(0, 15) == 0);
            io_alarm_arm = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 19) == 0) io_fast = ~io_fast;
            if ($urandom_range(0, 29) == 0) io_mode12 = ~io_mode12;
            if (io_alarm_arm) begin
                if ($urandom_range(0, 1) == 1) begin
                    io_alarm_hrs = cnt_hrs;
                    io_alarm_min = (cnt_min + 1) % 60;
                end else begin
                    io_alarm_hrs = $urandom_range(0, 25);
                    io_alarm_min = $urandom_range(0, 62);
                end
            end
            load_req = ($urandom_range(0, 199) == 0);
            load_hrs = $urandom_range(0, 11);
            load_min = $urandom_range(0, 59);
            load_sec = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 59);
        end
        @(negedge clk);
        io_reset = 1'b0; io_start = 1'b0; io_stop = 1'b0; io_fast = 1'b0;
        io_alarm_arm = 1'b0; io_alarm_ack = 1'b0; load_req = 1'b0;
    endtask

    initial begin
        io_reset = 1'b1; io_start = 1'b0; io_stop = 1'b0; io_fast = 1'b0; io_mode12 = 1'b0;
        io_alarm_arm = 1'b0; io_alarm_ack = 1'b0; io_alarm_hrs = '0; io_alarm_min = '0;
        test_reset();
        test_start_run();
        test_stop_priority();
        test_fast();
        test_mode();
        test_alarm();
        test_alarm_ack_race();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
